// File: rtl/serv_ibus_fetch.sv
// Instruction fetch stage: one Wishbone classic read per request, with the
// returned word held in an instruction register that feeds the decoder.
module serv_ibus_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic        ALIGN_CHECK = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_req,
  input  logic [31:0] i_fetch_pc,
  output logic        o_fetch_ready,
  input  logic        i_flush,
  output logic [31:0] o_ibus_adr,
  output logic        o_ibus_cyc,
  input  logic [31:0] i_ibus_rdt,
  input  logic        i_ibus_ack,
  output logic        o_dec_en,
  output logic [31:0] o_instr,
  output logic [4:0]  o_opcode,
  output logic [2:0]  o_funct3,
  output logic        o_imm30,
  output logic        o_imm25,
  output logic        o_op20,
  output logic        o_op21,
  output logic        o_op22,
  output logic        o_op26,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic        o_illegal,
  output logic        o_misalign
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic        cyc_q, cyc_d;
  logic        ready_q, ready_d;
  logic [31:0] instr_q, instr_d;
  logic        illegal_q, illegal_d;
  logic        dec_en_q, dec_en_d;
  logic        misalign_q, misalign_d;

  logic        accept;
  logic        pc_bad;

  assign accept = i_fetch_req && (state_q == IDLE);
  assign pc_bad = ALIGN_CHECK && (i_fetch_pc[1:0] != 2'b00);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    cyc_d      = cyc_q;
    instr_d    = instr_q;
    illegal_d  = illegal_q;
    dec_en_d   = 1'b0;
    misalign_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (pc_bad) begin
            misalign_d = 1'b1;
          end else begin
            adr_d   = i_fetch_pc;
            cyc_d   = 1'b1;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (i_ibus_ack) begin
          cyc_d   = 1'b0;
          state_d = IDLE;
          if (!i_flush) begin
            instr_d   = i_ibus_rdt;
            illegal_d = (i_ibus_rdt[1:0] != 2'b11);
            dec_en_d  = 1'b1;
          end
        end else if (i_flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Classic Wishbone cannot abort, so hold the cycle until the slave acks.
        if (i_ibus_ack) begin
          cyc_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      adr_q      <= RESET_PC;
      cyc_q      <= 1'b0;
      ready_q    <= 1'b1;
      instr_q    <= NOP;
      illegal_q  <= 1'b0;
      dec_en_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      cyc_q      <= cyc_d;
      ready_q    <= ready_d;
      instr_q    <= instr_d;
      illegal_q  <= illegal_d;
      dec_en_q   <= dec_en_d;
      misalign_q <= misalign_d;
    end
  end

  assign o_fetch_ready = ready_q;
  assign o_ibus_adr    = adr_q;
  assign o_ibus_cyc    = cyc_q;
  assign o_dec_en      = dec_en_q;
  assign o_instr       = instr_q;
  assign o_illegal     = illegal_q;
  assign o_misalign    = misalign_q;

  // Decoder fields are plain slices of the instruction register.
  assign o_opcode = instr_q[6:2];
  assign o_funct3 = instr_q[14:12];
  assign o_imm30  = instr_q[30];
  assign o_imm25  = instr_q[25];
  assign o_op20   = instr_q[20];
  assign o_op21   = instr_q[21];
  assign o_op22   = instr_q[22];
  assign o_op26   = instr_q[26];
  assign o_rs1    = instr_q[19:15];
  assign o_rs2    = instr_q[24:20];
  assign o_rd     = instr_q[11:7];

endmodule
